// File: rtl/reg_alu_sequencer.sv
// Sequences one register-file instruction (ADD/SUB/AND/LDI) through read, read, write phases.
// Latency: WRITE is 3 cycles after acceptance for ALU ops, 1 cycle for LDI; one op in flight.
// Backpressure: instr_ready is high only in IDLE; instr_valid in any other state is dropped.
module reg_alu_sequencer #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [DW-1:0] imm,
  output logic          wr_en,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic [AW-1:0] r_addr,
  input  logic [DW-1:0] r_data,
  output logic          done,
  output logic          carry,
  output logic          zero
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  typedef enum logic [1:0] {IDLE, READ_A, READ_B, WRITE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] result;
  logic          result_carry;

  // State register; reset returns to IDLE and abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: LDI skips both operand reads since it needs no register data.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = (op == OP_LDI) ? WRITE : READ_A;
      READ_A:  state_nxt = READ_B;
      READ_B:  state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces handshake and write strobes low.
  always_comb begin
    instr_ready = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    r_addr      = '0;
    case (state)
      IDLE:    instr_ready = ~rst;
      READ_A:  r_addr = rs1_q;
      READ_B:  r_addr = rs2_q;
      WRITE: begin
        wr_en = ~rst;
        done  = ~rst;
      end
      default: ;
    endcase
  end

  // Instruction fields captured once at acceptance and held until back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_ADD;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (state == IDLE && instr_valid) begin
      op_q  <= op;
      rd_q  <= rd;
      rs1_q <= rs1;
      rs2_q <= rs2;
      imm_q <= imm;
    end
  end

  // Operands are captured before WRITE, so rd aliasing a source sees pre-write values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (state == READ_A) a_reg <= r_data;
      if (state == READ_B) b_reg <= r_data;
    end
  end

  // ALU: carry is the sum overflow bit for ADD and the borrow for SUB.
  always_comb begin
    sum          = {1'b0, a_reg} + {1'b0, b_reg};
    diff         = {1'b0, a_reg} - {1'b0, b_reg};
    result       = '0;
    result_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        result       = sum[DW-1:0];
        result_carry = sum[DW];
      end
      OP_SUB: begin
        result       = diff[DW-1:0];
        result_carry = diff[DW];
      end
      OP_AND:  result = a_reg & b_reg;
      OP_LDI:  result = imm_q;
      default: result = '0;
    endcase
  end

  assign w_addr = rd_q;
  assign w_data = result;

  // Flags reflect the last instruction that actually reached its write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (state == WRITE) begin
      carry <= result_carry;
      zero  <= (result == '0);
    end
  end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
module tb_reg_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] op;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic [7:0] imm;
  logic       wr_en;
  logic [1:0] w_addr;
  logic [7:0] w_data;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic       done;
  logic       carry;
  logic       zero;

  int checks = 0;
  int errors = 0;

  // Register file environment around the sequencer.
  logic [7:0] rf [4];
  // Reference architectural register contents.
  int ref_rf [4];

  reg_alu_sequencer #(.DW(8), .AW(2)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr), .r_data(r_data), .done(done), .carry(carry), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign r_data = rf[r_addr];
  always @(posedge clk) if (wr_en) rf[w_addr] <= w_data;

  // Issue one instruction from an IDLE negedge and check every cycle until back in IDLE.
  task automatic exec(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [7:0] im);
    int a, b, res, c, lat, exp_ra, exp_zero;
    a = ref_rf[s1];
    b = ref_rf[s2];
    case (o)
      2'd0: begin res = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
      2'd1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2'd2: begin res = a & b; c = 0; end
      default: begin res = int'(im); c = 0; end
    endcase
    exp_zero = (res == 0) ? 1 : 0;
    lat = (o == 2'd3) ? 1 : 3;

    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready: instr_ready=%b want 1", instr_ready);
    end
    instr_valid = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      exp_ra = (lat == 3 && k == 1) ? int'(s1) : (lat == 3 && k == 2) ? int'(s2) : 0;
      checks++;
      if (r_addr !== exp_ra[1:0]) begin
        errors++; $display("FAIL r_addr cyc%0d op%0d: got %0d want %0d", k, o, r_addr, exp_ra);
      end
      checks++;
      if (wr_en !== (k == lat) || done !== (k == lat)) begin
        errors++; $display("FAIL wr_en/done cyc%0d op%0d: got %b/%b want %b", k, o, wr_en, done, (k == lat));
      end
      checks++;
      if (instr_ready !== 1'b0) begin
        errors++; $display("FAIL busy_ready cyc%0d: instr_ready=%b want 0", k, instr_ready);
      end
      if (k == lat) begin
        checks++;
        if (w_addr !== d || w_data !== res[7:0]) begin
          errors++; $display("FAIL write op%0d: w_addr=%0d w_data=%0d want %0d/%0d", o, w_addr, w_data, d, res);
        end
      end
      // Keep the request lines busy with junk that must be ignored.
      instr_valid = 1'($urandom_range(0, 1));
      op = 2'($urandom); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom); imm = 8'($urandom);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    checks++;
    if (carry !== c[0] || zero !== exp_zero[0]) begin
      errors++; $display("FAIL flags op%0d: carry=%b zero=%b want %0d/%0d", o, carry, zero, c, exp_zero);
    end
    checks++;
    if (instr_ready !== 1'b1 || wr_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_return: ready=%b wr_en=%b done=%b want 1/0/0", instr_ready, wr_en, done);
    end
    checks++;
    if (rf[d] !== res[7:0]) begin
      errors++; $display("FAIL rf_update r%0d: got %0d want %0d", d, rf[d], res);
    end
    ref_rf[d] = res;
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; op = 2'd0; rd = 2'd0; rs1 = 2'd0; rs2 = 2'd0; imm = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: ready=%b wr_en=%b done=%b want 0/0/0", instr_ready, wr_en, done);
    end
    checks++;
    if (carry !== 1'b0 || zero !== 1'b0 || r_addr !== 2'd0) begin
      errors++; $display("FAIL reset_state: carry=%b zero=%b r_addr=%0d want 0/0/0", carry, zero, r_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: instr_ready=%b want 1", instr_ready);
    end
  endtask

  task automatic test_ldi;
    exec(2'd3, 2'd0, 2'd0, 2'd0, 8'd100);
    exec(2'd3, 2'd1, 2'd0, 2'd0, 8'd101);
  endtask

  task automatic test_add;
    exec(2'd0, 2'd2, 2'd0, 2'd1, 8'd0);     // 100 + 101 = 201
    exec(2'd3, 2'd2, 2'd0, 2'd0, 8'd200);
    exec(2'd3, 2'd1, 2'd0, 2'd0, 8'd100);
    exec(2'd0, 2'd3, 2'd2, 2'd1, 8'd0);     // 200 + 100 = 44, carry
  endtask

  task automatic test_sub_and;
    exec(2'd1, 2'd3, 2'd1, 2'd1, 8'd0);     // r1 - r1 = 0, zero
    exec(2'd3, 2'd0, 2'd0, 2'd0, 8'd5);
    exec(2'd3, 2'd1, 2'd0, 2'd0, 8'd6);
    exec(2'd1, 2'd2, 2'd0, 2'd1, 8'd0);     // 5 - 6 = 255, borrow
    exec(2'd3, 2'd1, 2'd0, 2'd0, 8'hF0);
    exec(2'd3, 2'd2, 2'd0, 2'd0, 8'h3C);
    exec(2'd2, 2'd1, 2'd1, 2'd2, 8'd0);     // F0 & 3C = 30
  endtask

  task automatic test_same_reg;
    exec(2'd3, 2'd0, 2'd0, 2'd0, 8'd100);
    exec(2'd0, 2'd0, 2'd0, 2'd0, 8'd0);     // r0 = r0 + r0 = 200
  endtask

  task automatic test_reset_abort;
    exec(2'd3, 2'd0, 2'd0, 2'd0, 8'd5);
    exec(2'd3, 2'd1, 2'd0, 2'd0, 8'd6);
    exec(2'd1, 2'd3, 2'd0, 2'd1, 8'd0);     // leaves carry=1
    instr_valid = 1'b1; op = 2'd0; rd = 2'd2; rs1 = 2'd0; rs2 = 2'd1; imm = 8'd0;
    @(negedge clk);                          // READ_A
    instr_valid = 1'b0;
    @(negedge clk);                          // READ_B
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b0) begin
      errors++; $display("FAIL abort_strobes: wr_en=%b done=%b ready=%b want 0/0/0", wr_en, done, instr_ready);
    end
    checks++;
    if (carry !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL abort_flags: carry=%b zero=%b want 0/0", carry, zero);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready: instr_ready=%b want 1", instr_ready);
    end
    checks++;
    if (rf[2] !== ref_rf[2][7:0]) begin
      errors++; $display("FAIL abort_nowrite: r2=%0d want %0d", rf[2], ref_rf[2]);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      exec(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ref_rf[i] = 0;
    test_reset();
    test_ldi();
    test_add();
    test_sub_and();
    test_same_reg();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
